adc_interface_axi: RTL and testbench
====================================

// Module: adc_interface_axi
// PURPOSE
//  AXI4-Lite slave that returns ADC samples on the read channel; the read-side
//  counterpart of the DAC write interface on the same peripheral bus.
//  Each accepted AR transaction starts one conversion (SOC pulse) on the external ADC.
//  It waits for end-of-conversion (EOC), captures DIN and returns it on R.
//  The write channel is handshaked and its data discarded (read-only peripheral).
// PARAMETERS
//  DATA_W   12  ADC sample width; RDATA[DATA_W-1:0] = sample, upper bits 0
//  TIMEOUT  16  cycles in WAIT_EOC before abort (used only with ADC_TIMEOUT_EN)
// PORTS
//  Reset RST is asynchronous, active-low. Clock is CLK.
//  CLK      in   1       clock
//  RST      in   1       async reset, active-low
//  ARVALID  in   1       read address valid
//  ARREADY  out  1       read address ready
//  RVALID   out  1       read data valid
//  RREADY   in   1       read data ready
//  RDATA    out  32      read data
//  AWVALID  in   1       write address valid
//  AWREADY  out  1       write address ready
//  WVALID   in   1       write data valid
//  WREADY   out  1       write data ready
//  AWADDR   in   32      ignored
//  WDATA    in   32      ignored
//  WSTRB    in   4       ignored
//  BVALID   out  1       write response valid
//  BREADY   in   1       write response ready
//  SOC      out  1       start-of-conversion to ADC, one-cycle pulse
//  EOC      in   1       end-of-conversion from ADC, asynchronous
//  DIN      in   DATA_W  ADC parallel data; stable while EOC is high
// BEHAVIOUR
//  Reset: all outputs are 0. Read FSM goes to R_IDLE; write FSM goes to W_IDLE.
//    The sample register, EOC synchroniser and counters are cleared.
//    Reset mid-operation aborts the transaction with no response.
//  Read FSM:
//    R_IDLE: ARVALID=1 -> R_ADDR.
//    R_ADDR: ARREADY=1 for exactly 1 cycle -> R_SOC.
//    R_SOC: SOC=1 for exactly 1 cycle -> R_WAIT. Clears the timeout counter.
//    R_WAIT: a rising edge of synchronised EOC (EOC_s=1 and previous=0) loads DIN
//      into the sample register -> R_RESP.
//    R_RESP: RVALID=1 and RDATA={'0, sample}. Both are held stable until RREADY=1
//      is sampled; then go to R_IDLE and drop RVALID on the next cycle.
//  EOC path: 2-flop synchroniser; DIN is captured in the cycle the edge is detected.
//    EOC already high on entry to R_WAIT is not captured; a low-then-high edge is required.
//    EOC activity outside R_WAIT is ignored.
//  Latency: ARVALID sampled at cycle N -> ARREADY at N+1 -> SOC at N+2.
//    RVALID rises 1 cycle after the EOC edge is detected (3 cycles after raw EOC rises).
//  Write FSM (independent; runs concurrently with reads):
//    W_IDLE: AWVALID=1 and WVALID=1 -> W_ACK.
//    W_ACK: AWREADY=WREADY=1 for 1 cycle -> W_RESP.
//    W_RESP: BVALID=1 until BREADY=1 is sampled -> W_IDLE.
//    Only one of AWVALID/WVALID high: stay in W_IDLE. Writes never alter RDATA or SOC.
//  ARVALID held high through R_RESP starts no new transaction until R_IDLE is re-entered.
//  Unknown states recover to R_IDLE/W_IDLE.
// CONFIGURATION
//  ADC_TIMEOUT_EN defined:
//    - 5-bit counter increments each cycle in R_WAIT.
//    - On reaching TIMEOUT without an EOC edge -> R_RESP with RDATA[31]=1 and
//      RDATA[DATA_W-1:0] = previous sample (unchanged).
//    - RDATA[31]=0 on normal completion.
//  ADC_TIMEOUT_EN undefined: R_WAIT waits for EOC forever; RDATA[31] is always 0.
// TESTING
//  1) Assert RST=0 mid-run -> all outputs 0 within the same cycle, asynchronously.
//  2) ARVALID pulse at N; EOC rises at N+7 with DIN=12'hA5C.
//     -> ARREADY at N+1, SOC at N+2, RVALID with RDATA=32'h00000A5C; RREADY held
//     low 3 cycles -> RVALID and RDATA held stable; RREADY=1 -> RVALID=0 next cycle.
//  3) AWVALID=WVALID=1 with WDATA=32'h1234 -> AWREADY/WREADY=1 for 1 cycle;
//     BVALID holds until BREADY; a following read still returns the ADC sample.
//  4) ADC_TIMEOUT_EN defined, last sample 12'hA5C, no EOC -> RVALID after TIMEOUT
//     cycles in R_WAIT with RDATA=32'h80000A5C; with the macro undefined, RVALID stays 0.
//  5) EOC held high from before SOC -> no capture; EOC low then high with DIN=12'h3FF
//     -> RDATA=32'h000003FF.
//  6) RST=0 during R_WAIT -> SOC=0, RVALID=0; after release, a read with DIN=12'h001
//     completes normally with RDATA=32'h00000001.

Source files
------------

// File: rtl/adc_interface_axi_if.sv
// AXI4-Lite read/write channel bundle for the ADC peripheral.
// The slave modport is the DUT view; the master modport is the bus/bench view.
interface adc_interface_axi_if;
  logic        ARVALID;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic        AWVALID;
  logic        AWREADY;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] AWADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;

  modport slave (
    input  ARVALID, RREADY, AWVALID, WVALID, AWADDR, WDATA, WSTRB, BREADY,
    output ARREADY, RVALID, RDATA, AWREADY, WREADY, BVALID
  );

  modport master (
    output ARVALID, RREADY, AWVALID, WVALID, AWADDR, WDATA, WSTRB, BREADY,
    input  ARREADY, RVALID, RDATA, AWREADY, WREADY, BVALID
  );
endinterface

// File: rtl/adc_interface_axi.sv
// AXI4-Lite read-only ADC front end: each AR starts one conversion and returns the sample on R.
// Define ADC_TIMEOUT_EN to abort a conversion after TIMEOUT cycles (RDATA[31] flags the abort).
module adc_interface_axi #(
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  adc_interface_axi_if.slave axi,
  output logic              SOC_o,
  input  logic              EOC_i,
  input  logic [DATA_W-1:0] DIN_i
);

  typedef enum logic [2:0] {
    R_IDLE = 3'd0,
    R_ADDR = 3'd1,
    R_SOC  = 3'd2,
    R_WAIT = 3'd3,
    R_RESP = 3'd4
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  r_state_e          r_state_q, r_state_d;
  w_state_e          w_state_q, w_state_d;
  logic              eoc_meta_q, eoc_sync_q, eoc_prev_q;
  logic              eoc_rise_s;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              timeout_q, timeout_d;
  logic              arready_q, arready_d;
  logic              soc_q, soc_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic              unused_s;
`ifdef ADC_TIMEOUT_EN
  logic [4:0]        cnt_q, cnt_d;
`endif

  function automatic logic [31:0] pack_rdata(input logic flag, input logic [DATA_W-1:0] smp);
    logic [31:0] word;
    word             = 32'd0;
    word[DATA_W-1:0] = smp;
    word[31]         = flag;
    return word;
  endfunction

  // Write address/data/strobe are deliberately discarded.
  assign unused_s   = ^{axi.AWADDR, axi.WDATA, axi.WSTRB};
  assign eoc_rise_s = eoc_sync_q & ~eoc_prev_q;

  // EOC synchroniser and edge-history flop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      eoc_meta_q <= 1'b0;
      eoc_sync_q <= 1'b0;
      eoc_prev_q <= 1'b0;
    end else begin
      eoc_meta_q <= EOC_i;
      eoc_sync_q <= eoc_meta_q;
      eoc_prev_q <= eoc_sync_q;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      sample_q  <= '0;
      timeout_q <= 1'b0;
      arready_q <= 1'b0;
      soc_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      cnt_q     <= 5'd0;
`endif
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      sample_q  <= sample_d;
      timeout_q <= timeout_d;
      arready_q <= arready_d;
      soc_q     <= soc_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
`ifdef ADC_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Read FSM next state plus sample/timeout capture
  always_comb begin
    r_state_d = r_state_q;
    sample_d  = sample_q;
    timeout_d = timeout_q;
`ifdef ADC_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (axi.ARVALID) r_state_d = R_ADDR;
        else             r_state_d = R_IDLE;
      end
      R_ADDR: r_state_d = R_SOC;
      R_SOC: begin
        r_state_d = R_WAIT;
        timeout_d = 1'b0;
`ifdef ADC_TIMEOUT_EN
        cnt_d     = 5'd0;
`endif
      end
      R_WAIT: begin
`ifdef ADC_TIMEOUT_EN
        cnt_d = cnt_q + 5'd1;
        if (eoc_rise_s) begin
          sample_d  = DIN_i;
          r_state_d = R_RESP;
        end else if (cnt_q == 5'(TIMEOUT - 1)) begin
          // Abort keeps the previous sample and only raises the flag.
          timeout_d = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_WAIT;
        end
`else
        if (eoc_rise_s) begin
          sample_d  = DIN_i;
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_WAIT;
        end
`endif
      end
      R_RESP: begin
        if (axi.RREADY) r_state_d = R_IDLE;
        else            r_state_d = R_RESP;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi.AWVALID && axi.WVALID) w_state_d = W_ACK;
        else                           w_state_d = W_IDLE;
      end
      W_ACK: w_state_d = W_RESP;
      W_RESP: begin
        if (axi.BREADY) w_state_d = W_IDLE;
        else            w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it
  always_comb begin
    arready_d = (r_state_d == R_ADDR);
    soc_d     = (r_state_d == R_SOC);
    rvalid_d  = (r_state_d == R_RESP);
    awready_d = (w_state_d == W_ACK);
    wready_d  = (w_state_d == W_ACK);
    bvalid_d  = (w_state_d == W_RESP);
    if (r_state_d == R_RESP) rdata_d = pack_rdata(timeout_d, sample_d);
    else                     rdata_d = 32'd0;
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = bvalid_q;
  assign SOC_o       = soc_q;

endmodule

// File: tb/tb_adc_interface_axi.sv
// Directed bench for adc_interface_axi: reset, read latency/hold, writes, timeout, EOC edge rules.
module tb_adc_interface_axi;
  logic        CLK = 1'b0;
  logic        RST;
  logic        SOC;
  logic        EOC;
  logic [11:0] DIN;
  int          checks = 0;
  int          errors = 0;

  adc_interface_axi_if axi ();

  adc_interface_axi #(.DATA_W(12), .TIMEOUT(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .axi   (axi),
    .SOC_o (SOC),
    .EOC_i (EOC),
    .DIN_i (DIN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full read with an EOC edge raised on the first wait cycle; no checking here.
  task automatic do_read(input logic [11:0] din, output logic [31:0] data, output bit got);
    got  = 1'b0;
    data = 32'd0;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    tick();
    tick();
    DIN = din;
    EOC = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (axi.RVALID === 1'b1) begin
        got  = 1'b1;
        data = axi.RDATA;
      end
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    EOC = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    checks++;
    if ({axi.ARREADY, axi.RVALID, axi.AWREADY, axi.WREADY, axi.BVALID, SOC} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {axi.ARREADY, axi.RVALID, axi.AWREADY, axi.WREADY, axi.BVALID, SOC});
    end
    checks++;
    if (axi.RDATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", axi.RDATA);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    axi.ARVALID = 1'b1;
    axi.AWVALID = 1'b1;
    axi.WVALID  = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    tick();
    checks++;
    if ({SOC, axi.BVALID} !== 2'b11) begin
      errors++;
      $display("FAIL async_pre: got SOC,BVALID=%b expected 11", {SOC, axi.BVALID});
    end
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({axi.ARREADY, axi.RVALID, axi.AWREADY, axi.WREADY, axi.BVALID, SOC} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000",
               {axi.ARREADY, axi.RVALID, axi.AWREADY, axi.WREADY, axi.BVALID, SOC});
    end
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_read_basic();
    EOC = 1'b0;
    DIN = 12'hA5C;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    checks++;
    if ({axi.ARREADY, SOC} !== 2'b10) begin
      errors++;
      $display("FAIL rd_arready: got ARREADY,SOC=%b expected 10", {axi.ARREADY, SOC});
    end
    tick();
    checks++;
    if ({axi.ARREADY, SOC} !== 2'b01) begin
      errors++;
      $display("FAIL rd_soc: got ARREADY,SOC=%b expected 01", {axi.ARREADY, SOC});
    end
    tick();
    checks++;
    if (SOC !== 1'b0) begin
      errors++;
      $display("FAIL rd_soc_pulse: got %b expected 0", SOC);
    end
    repeat (4) tick();
    EOC = 1'b1;
    tick();
    tick();
    checks++;
    if (axi.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_rvalid: got %b expected 0", axi.RVALID);
    end
    tick();
    checks++;
    if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h00000A5C) begin
      errors++;
      $display("FAIL rd_data: got RVALID=%b RDATA=%h expected 1 00000a5c", axi.RVALID, axi.RDATA);
    end
    DIN = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h00000A5C) begin
        errors++;
        $display("FAIL rd_hold%0d: got RVALID=%b RDATA=%h expected 1 00000a5c",
                 i, axi.RVALID, axi.RDATA);
      end
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    EOC = 1'b0;
    checks++;
    if (axi.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_release: got RVALID=%b expected 0", axi.RVALID);
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    logic [31:0] data;
    bit          got;
    bit          seen;
    DIN = 12'h777;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    tick();
    tick();
`ifdef ADC_TIMEOUT_EN
    repeat (15) tick();
    checks++;
    if (axi.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL to_early: got RVALID=%b expected 0", axi.RVALID);
    end
    tick();
    checks++;
    if (axi.RVALID !== 1'b1 || axi.RDATA !== 32'h80000A5C) begin
      errors++;
      $display("FAIL to_data: got RVALID=%b RDATA=%h expected 1 80000a5c", axi.RVALID, axi.RDATA);
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    tick();
    seen = 1'b0;
    got  = 1'b0;
    data = 32'd0;
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | (axi.RVALID === 1'b1);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL to_disabled: got RVALID seen=%b expected 0", seen);
    end
    DIN = 12'hA5C;
    EOC = 1'b1;
    got = 1'b0;
    data = 32'd0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (axi.RVALID === 1'b1) begin
        got  = 1'b1;
        data = axi.RDATA;
      end
    end
    checks++;
    if (!got || data !== 32'h00000A5C) begin
      errors++;
      $display("FAIL to_late_eoc: got valid=%b RDATA=%h expected 1 00000a5c", got, data);
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    EOC = 1'b0;
    repeat (3) tick();
`endif
  endtask

  task automatic test_write();
    logic [31:0] data;
    bit          got;
    axi.AWVALID = 1'b1;
    axi.WDATA   = 32'h1234;
    tick();
    tick();
    checks++;
    if ({axi.AWREADY, axi.WREADY, axi.BVALID} !== 3'b000) begin
      errors++;
      $display("FAIL wr_aw_only: got %b expected 000", {axi.AWREADY, axi.WREADY, axi.BVALID});
    end
    axi.WVALID = 1'b1;
    tick();
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    checks++;
    if ({axi.AWREADY, axi.WREADY, axi.BVALID} !== 3'b110) begin
      errors++;
      $display("FAIL wr_ack: got %b expected 110", {axi.AWREADY, axi.WREADY, axi.BVALID});
    end
    tick();
    tick();
    checks++;
    if ({axi.AWREADY, axi.WREADY, axi.BVALID, SOC, axi.RVALID} !== 5'b00100) begin
      errors++;
      $display("FAIL wr_bvalid_hold: got %b expected 00100",
               {axi.AWREADY, axi.WREADY, axi.BVALID, SOC, axi.RVALID});
    end
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    checks++;
    if (axi.BVALID !== 1'b0) begin
      errors++;
      $display("FAIL wr_bready: got BVALID=%b expected 0", axi.BVALID);
    end
    do_read(12'h5A3, data, got);
    checks++;
    if (!got || data !== 32'h000005A3) begin
      errors++;
      $display("FAIL wr_then_read: got valid=%b RDATA=%h expected 1 000005a3", got, data);
    end
  endtask

  task automatic test_eoc_held();
    logic [31:0] data;
    bit          got;
    EOC = 1'b1;
    DIN = 12'h0AA;
    repeat (3) tick();
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    tick();
    tick();
    repeat (5) tick();
    checks++;
    if (axi.RVALID !== 1'b0) begin
      errors++;
      $display("FAIL held_eoc: got RVALID=%b expected 0", axi.RVALID);
    end
    EOC = 1'b0;
    DIN = 12'h3FF;
    repeat (3) tick();
    EOC = 1'b1;
    got  = 1'b0;
    data = 32'd0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (axi.RVALID === 1'b1) begin
        got  = 1'b1;
        data = axi.RDATA;
      end
    end
    checks++;
    if (!got || data !== 32'h000003FF) begin
      errors++;
      $display("FAIL held_then_edge: got valid=%b RDATA=%h expected 1 000003ff", got, data);
    end
    axi.RREADY = 1'b1;
    tick();
    axi.RREADY = 1'b0;
    EOC = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_wait();
    logic [31:0] data;
    bit          got;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    tick();
    tick();
    tick();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({SOC, axi.RVALID} !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait: got SOC,RVALID=%b expected 00", {SOC, axi.RVALID});
    end
    tick();
    RST = 1'b1;
    tick();
    EOC = 1'b1;
    repeat (5) tick();
    checks++;
    if ({SOC, axi.RVALID} !== 2'b00) begin
      errors++;
      $display("FAIL idle_eoc: got SOC,RVALID=%b expected 00", {SOC, axi.RVALID});
    end
    EOC = 1'b0;
    repeat (3) tick();
    do_read(12'h001, data, got);
    checks++;
    if (!got || data !== 32'h00000001) begin
      errors++;
      $display("FAIL rst_recover: got valid=%b RDATA=%h expected 1 00000001", got, data);
    end
  endtask

  initial begin
    RST         = 1'b0;
    EOC         = 1'b0;
    DIN         = 12'h000;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.AWADDR  = 32'd0;
    axi.WDATA   = 32'd0;
    axi.WSTRB   = 4'hF;
    axi.BREADY  = 1'b0;
    #2;
    test_reset();
    test_async_reset();
    test_read_basic();
    test_timeout();
    test_write();
    test_eoc_held();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
